// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared state/phase encodings and bus constants for the Z80 memory read sequencers.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPLO,
        ST_OPHI,
        ST_DAT0,
        ST_DAT1,
        ST_FIN
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_T1,
        PH_T2,
        PH_TW,
        PH_T3
    } t_phase_e;

    localparam int T_RD_MEM = 3;

    // z80fi M-cycle type codes
    localparam logic [1:0] CYCLE_NONE     = 2'd0;
    localparam logic [1:0] CYCLE_RDWR_MEM = 2'd1;
    localparam logic [1:0] CYCLE_RDWR_IO  = 2'd2;
    localparam logic [1:0] CYCLE_INTACK   = 2'd3;

endpackage

// File: rtl/z80_mem_read_cycle.sv
// z80_mem_read_cycle: one T1/T2/Tw*/T3 memory read with /WAIT handling.
// Ports: req_i holds the cycle active (phases advance only while high), addr_i/addr_o bus address,
// mreq_n_o/rd_n_o strobes, wait_n_i /WAIT, data_i bus data; data_o/done_o/tcycles_o are
// registered at the end of T3, so done_o is high in the cycle after T3.
module z80_mem_read_cycle
    import z80_bus_pkg::*;
#(
    parameter int WAIT_EN = 1,
    parameter int MAX_TW  = 7
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        req_i,
    input  logic [15:0] addr_i,
    input  logic        wait_n_i,
    input  logic [7:0]  data_i,
    output logic [15:0] addr_o,
    output logic        mreq_n_o,
    output logic        rd_n_o,
    output logic [7:0]  data_o,
    output logic        done_o,
    output logic [3:0]  tcycles_o
);

    if (MAX_TW < 0 || MAX_TW > 12) begin : g_bad_max_tw
        $error("MAX_TW must be 0..12");
    end

    localparam logic [3:0] TW_SAT = 4'(MAX_TW);

    t_phase_e   phase_q, phase_d;
    logic [3:0] tw_q, tw_d, tcyc_q, tcyc_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;

    always_comb begin
        phase_d = phase_q;
        tw_d    = tw_q;
        tcyc_d  = tcyc_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (req_i) begin
            case (phase_q)
                PH_T1: begin
                    phase_d = PH_T2;
                    tw_d    = 4'd0;
                end
                PH_T2: phase_d = (WAIT_EN != 0 && !wait_n_i) ? PH_TW : PH_T3;
                PH_TW: begin
                    phase_d = wait_n_i ? PH_T3 : PH_TW;
                    tw_d    = (tw_q == TW_SAT) ? tw_q : tw_q + 4'd1;
                end
                default: begin
                    phase_d = PH_T1;
                    done_d  = 1'b1;
                    tcyc_d  = 4'(T_RD_MEM) + tw_q;
                    data_d  = data_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q <= PH_T1;
            tw_q    <= 4'd0;
            tcyc_q  <= 4'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tw_q    <= tw_d;
            tcyc_q  <= tcyc_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign addr_o    = req_i ? addr_i : 16'd0;
    assign mreq_n_o  = !req_i;
    assign rd_n_o    = !req_i;
    assign data_o    = data_q;
    assign done_o    = done_q;
    assign tcycles_o = tcyc_q;

endmodule

// File: rtl/z80_ind_nn_read_seq.sv
// z80_ind_nn_read_seq: M-cycle sequencer for LD A,(nn) / LD rr,(nn): fetch nn, then read NBYTES bytes at nn.
// Ports: start_i/pc_in_i launch an operation, wait_n_i and data_in_i come from the bus,
// addr_o/mreq_n_o/rd_n_o drive it; busy_o, done_o, result_o, nn_out_o, pc_out_o report the
// operation, mc_valid_o/mc_tcycles_o report each finished M-cycle to the trace path.
module z80_ind_nn_read_seq
    import z80_bus_pkg::*;
#(
    parameter int NBYTES  = 1,
    parameter int WAIT_EN = 1,
    parameter int MAX_TW  = 7
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [15:0]           pc_in_i,
    input  logic                  wait_n_i,
    input  logic [7:0]            data_in_i,
    output logic [15:0]           addr_o,
    output logic                  mreq_n_o,
    output logic                  rd_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [8*NBYTES-1:0]   result_o,
    output logic [15:0]           nn_out_o,
    output logic [15:0]           pc_out_o,
    output logic                  mc_valid_o,
    output logic [3:0]            mc_tcycles_o
);

    if (NBYTES != 1 && NBYTES != 2) begin : g_bad_nbytes
        $error("NBYTES must be 1 or 2");
    end

    seq_state_e          state_q, state_d;
    logic [15:0]         pc3_q, pc3_d, nn_q, nn_d, rd_addr;
    logic [8*NBYTES-1:0] res_q, res_d;
    logic                armed_q, mc_valid, req;
    logic [7:0]          rdata;

    // The gap cycle between M-cycles is the one where the read cycle reports completion.
    assign req = (state_q inside {ST_OPLO, ST_OPHI, ST_DAT0, ST_DAT1}) && !mc_valid;

    // pc+3 is kept instead of pc so pc_out reads 0 out of reset; operand addresses derive from it.
    assign rd_addr = state_q == ST_OPLO ? pc3_q - 16'd2 :
                     state_q == ST_OPHI ? pc3_q - 16'd1 :
                     state_q == ST_DAT0 ? nn_q : nn_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc3_d   = pc3_q;
        nn_d    = nn_q;
        res_d   = res_q;
        if (state_q == ST_IDLE && start_i && armed_q) begin
            state_d = ST_OPLO;
            pc3_d   = pc_in_i + 16'd3;
        end
        if (state_q == ST_FIN) state_d = ST_IDLE;
        if (mc_valid) begin
            state_d = state_q == ST_OPLO ? ST_OPHI :
                      state_q == ST_OPHI ? ST_DAT0 :
                      (state_q == ST_DAT0 && NBYTES == 2) ? ST_DAT1 : ST_FIN;
            if (state_q == ST_OPLO) nn_d[7:0] = rdata;
            if (state_q == ST_OPHI) nn_d[15:8] = rdata;
            if (state_q == ST_DAT0) res_d[7:0] = rdata;
            if (state_q == ST_DAT1) res_d[8*NBYTES-1 -: 8] = rdata;
        end
    end

    // armed_q blocks a start that coincides with reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            pc3_q   <= 16'd0;
            nn_q    <= 16'd0;
            res_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc3_q   <= pc3_d;
            nn_q    <= nn_d;
            res_q   <= res_d;
            armed_q <= 1'b1;
        end
    end

    z80_mem_read_cycle #(
        .WAIT_EN(WAIT_EN),
        .MAX_TW (MAX_TW)
    ) u_rd (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .req_i    (req),
        .addr_i   (rd_addr),
        .wait_n_i (wait_n_i),
        .data_i   (data_in_i),
        .addr_o   (addr_o),
        .mreq_n_o (mreq_n_o),
        .rd_n_o   (rd_n_o),
        .data_o   (rdata),
        .done_o   (mc_valid),
        .tcycles_o(mc_tcycles_o)
    );

    assign busy_o     = state_q != ST_IDLE;
    assign done_o     = state_q == ST_FIN;
    assign result_o   = res_q;
    assign nn_out_o   = nn_q;
    assign pc_out_o   = pc3_q;
    assign mc_valid_o = mc_valid;

endmodule

// File: tb/tb_z80_ind_nn_read_seq.sv
// tb_z80_ind_nn_read_seq: three sequencer variants (1 byte, 2 bytes, 1 byte without waits) on one memory model.
module tb_z80_ind_nn_read_seq;

    localparam int NB [3]  = '{1, 2, 1};
    localparam int WE [3]  = '{1, 1, 0};
    localparam int MAX_TW  = 7;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  lo, hi, d0, d1;
        int          k, w, glitch;
        logic [15:0] nn, res, pco;
        int          lat1, lat2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n, start, wait_n;
    logic [15:0] pc_in;
    logic [7:0]  mem [65536];
    logic [15:0] addr [3], nn_out [3], pc_out [3];
    logic        mreq_n [3], rd_n [3], busy [3], done [3], mc_valid [3];
    logic [3:0]  tc [3];
    logic [7:0]  res_a, res_c;
    logic [15:0] res_b;
    int          tests = 0, fails = 0;
    vec_t        tbl [5];
    vec_t        rv;

    always #5 clk = ~clk;

    z80_ind_nn_read_seq #(.NBYTES(1), .WAIT_EN(1), .MAX_TW(MAX_TW)) u_b1 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .pc_in_i(pc_in), .wait_n_i(wait_n),
        .data_in_i(mem[addr[0]]), .addr_o(addr[0]), .mreq_n_o(mreq_n[0]), .rd_n_o(rd_n[0]),
        .busy_o(busy[0]), .done_o(done[0]), .result_o(res_a), .nn_out_o(nn_out[0]),
        .pc_out_o(pc_out[0]), .mc_valid_o(mc_valid[0]), .mc_tcycles_o(tc[0]));

    z80_ind_nn_read_seq #(.NBYTES(2), .WAIT_EN(1), .MAX_TW(MAX_TW)) u_b2 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .pc_in_i(pc_in), .wait_n_i(wait_n),
        .data_in_i(mem[addr[1]]), .addr_o(addr[1]), .mreq_n_o(mreq_n[1]), .rd_n_o(rd_n[1]),
        .busy_o(busy[1]), .done_o(done[1]), .result_o(res_b), .nn_out_o(nn_out[1]),
        .pc_out_o(pc_out[1]), .mc_valid_o(mc_valid[1]), .mc_tcycles_o(tc[1]));

    z80_ind_nn_read_seq #(.NBYTES(1), .WAIT_EN(0), .MAX_TW(MAX_TW)) u_nw (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .pc_in_i(pc_in), .wait_n_i(wait_n),
        .data_in_i(mem[addr[2]]), .addr_o(addr[2]), .mreq_n_o(mreq_n[2]), .rd_n_o(rd_n[2]),
        .busy_o(busy[2]), .done_o(done[2]), .result_o(res_c), .nn_out_o(nn_out[2]),
        .pc_out_o(pc_out[2]), .mc_valid_o(mc_valid[2]), .mc_tcycles_o(tc[2]));

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    function automatic logic [15:0] res_of(input int d);
        return d == 0 ? {8'h00, res_a} : d == 1 ? res_b : {8'h00, res_c};
    endfunction

    // Only the waited M-cycle stretches, and only on variants that honour /WAIT.
    function automatic int exp_tc(input int d, input int m, input int k, input int w);
        return (WE[d] != 0 && m == k) ? 3 + (w > MAX_TW ? MAX_TW : w) : 3;
    endfunction

    task automatic load(input vec_t v);
        mem[v.pc + 16'd1] = v.lo;
        mem[v.pc + 16'd2] = v.hi;
        mem[v.nn]         = v.d0;
        mem[v.nn + 16'd1] = v.d1;
    endtask

    task automatic run_op(input vec_t v);
        int          ndone [3], dcyc [3], na [3], nv [3], lat;
        logic        pm [3];
        logic [15:0] ea [4], gres [3], gnn [3], gpc [3], eres;
        ea[0] = v.pc + 16'd1;
        ea[1] = v.pc + 16'd2;
        ea[2] = v.nn;
        ea[3] = v.nn + 16'd1;
        for (int d = 0; d < 3; d++) begin
            ndone[d] = 0; dcyc[d] = -1; na[d] = 0; nv[d] = 0; pm[d] = 1'b1;
            gres[d] = '0; gnn[d] = '0; gpc[d] = '0;
        end
        @(posedge clk); #1;
        pc_in = v.pc;
        for (int c = 0; c < 48; c++) begin
            start  = (c == 0) || (v.glitch != 0 && (c == 6 || c == 13));
            wait_n = !(c >= 4 * v.k + 2 && c < 4 * v.k + 2 + v.w);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!mreq_n[d] && pm[d]) begin
                    if (na[d] < NB[d] + 2) check("addr", d, addr[d], ea[na[d]]);
                    na[d]++;
                end
                pm[d] = mreq_n[d];
                if (mc_valid[d]) begin
                    check("tcycles", d, tc[d], exp_tc(d, nv[d], v.k, v.w));
                    nv[d]++;
                end
                if (done[d]) begin
                    ndone[d]++;
                    if (dcyc[d] < 0) begin
                        dcyc[d] = c; gres[d] = res_of(d); gnn[d] = nn_out[d]; gpc[d] = pc_out[d];
                    end
                end
            end
            @(posedge clk); #1;
        end
        start  = 1'b0;
        wait_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            lat  = d == 0 ? v.lat1 : d == 1 ? v.lat2 : 13;
            eres = NB[d] == 2 ? v.res : {8'h00, v.res[7:0]};
            check("done_count", d, ndone[d], 1);
            check("latency", d, dcyc[d], lat);
            check("result", d, gres[d], eres);
            check("nn_out", d, gnn[d], v.nn);
            check("pc_out", d, gpc[d], v.pco);
            check("addr_count", d, na[d], NB[d] + 2);
            check("mcycle_count", d, nv[d], NB[d] + 2);
            check("result_hold", d, res_of(d), eres);
        end
    endtask

    initial begin
        int nd;
        tbl[0] = '{16'h1000, 8'h34, 8'h12, 8'hA5, 8'h5A, 0, 0, 1, 16'h1234, 16'h5AA5, 16'h1003, 13, 17};
        tbl[1] = '{16'h2000, 8'hFF, 8'hFF, 8'h11, 8'h22, 0, 0, 0, 16'hFFFF, 16'h2211, 16'h2003, 13, 17};
        tbl[2] = '{16'hFFFE, 8'h40, 8'h50, 8'h77, 8'h88, 0, 0, 0, 16'h5040, 16'h8877, 16'h0001, 13, 17};
        tbl[3] = '{16'h3000, 8'h00, 8'h40, 8'hC3, 8'h3C, 2, 2, 0, 16'h4000, 16'h3CC3, 16'h3003, 15, 19};
        tbl[4] = '{16'h3100, 8'h00, 8'h41, 8'h96, 8'h69, 1, 9, 0, 16'h4100, 16'h6996, 16'h3103, 22, 26};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset_n = 1'b0; start = 1'b0; wait_n = 1'b1; pc_in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_addr", d, addr[d], 16'h0000);
            check("rst_mreq_n", d, mreq_n[d], 1'b1);
            check("rst_rd_n", d, rd_n[d], 1'b1);
            check("rst_busy", d, busy[d], 1'b0);
            check("rst_done", d, done[d], 1'b0);
            check("rst_mc_valid", d, mc_valid[d], 1'b0);
            check("rst_tcycles", d, tc[d], 4'd0);
            check("rst_result", d, res_of(d), 16'h0000);
            check("rst_nn_out", d, nn_out[d], 16'h0000);
            check("rst_pc_out", d, pc_out[d], 16'h0000);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; start = 1'b1; pc_in = 16'h1000;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("start_at_release", d, busy[d], 1'b0);

        for (int i = 0; i < 5; i++) begin
            load(tbl[i]);
            run_op(tbl[i]);
        end

        load(tbl[0]);
        @(posedge clk); #1;
        start = 1'b1; pc_in = tbl[0].pc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check("dat0_t2_mreq_n", d, mreq_n[d], 1'b0);
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("abort_mreq_n", d, mreq_n[d], 1'b1);
            check("abort_rd_n", d, rd_n[d], 1'b1);
            check("abort_busy", d, busy[d], 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) nd += int'(done[d]);
        end
        check("abort_no_done", 0, nd, 0);
        run_op(tbl[0]);

        for (int i = 0; i < 20; i++) begin
            rv.pc = 16'($urandom);
            rv.lo = 8'($urandom);
            rv.hi = 8'($urandom);
            mem[rv.pc + 16'd1] = rv.lo;
            mem[rv.pc + 16'd2] = rv.hi;
            rv.nn     = {mem[rv.pc + 16'd2], mem[rv.pc + 16'd1]};
            rv.d0     = mem[rv.nn];
            rv.d1     = mem[rv.nn + 16'd1];
            rv.res    = {rv.d1, rv.d0};
            rv.pco    = rv.pc + 16'd3;
            rv.k      = int'($urandom_range(0, 2));
            rv.w      = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 10));
            rv.glitch = 0;
            rv.lat1   = 1 + 4 * 3 + rv.w;
            rv.lat2   = 1 + 4 * 4 + rv.w;
            run_op(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
